sar_code_capture: RTL and testbench
===================================

# sar_code_capture

Reader-side companion to the 6-bit SAR conversion logic. It detects each completed conversion on the SAR result strobe and captures the 6-bit code into a small FIFO. It drains the FIFO to on-chip user logic over a valid/ready stream. Sits between the SAR logic outputs (q5..q0, rs) and the user-project digital side, in the same clock domain as the SAR logic.

## Interface
Parameters:
- DEPTH, 8, FIFO depth in words; power of two, ≥2
- LVL_W, $clog2(DEPTH)+1, width of `level`

Ports. One clock; reset is asynchronous and active-high.
- clk  in  1  system clock, same clock driving the SAR logic
- rst  in  1  asynchronous, active-high reset
- start  in  1  one-cycle pulse; begins a capture run
- stop  in  1  one-cycle pulse; aborts a run
- flush  in  1  one-cycle pulse; empties FIFO, clears `overflow`
- burst_len  in  8  words to capture per run; 0 = continuous; latched on `start`
- code_in  in  6  SAR result, {q5..q0}; stable while `code_rdy` high
- code_rdy  in  1  SAR result strobe (rs); rising edge = new code
- out_data  out  8  FIFO head word
- out_valid  out  1  head word valid
- out_ready  in  1  consumer accepts head when high with `out_valid`
- level  out  LVL_W  FIFO occupancy, 0..DEPTH
- overflow  out  1  sticky; a word was dropped
- busy  out  1  high in RUN
- done  out  1  high in DONE

## Operation
- FSM states: IDLE, RUN, DONE.
  - IDLE→RUN on `start`.
  - RUN→DONE when the word count reaches a nonzero latched `burst_len`.
  - RUN→IDLE on `stop`.
  - DONE→RUN on `start`; DONE→IDLE on `stop`.
  - `start` in RUN restarts the run: the word count clears, `burst_len` is re-latched, and the FIFO is kept.
- Edge detect: `code_rdy_q` is the registered `code_rdy`. An event occurs on the edge where `code_rdy`=1 and `code_rdy_q`=0.
  - A held-high strobe counts once.
  - Events outside RUN are ignored. `code_rdy_q` still tracks.
- Word formation without averaging: word = {2'b00, code_in}, one word per event.
- Write:
  - A word is written if `level`<DEPTH, or if `level`==DEPTH and a pop occurs in the same cycle.
  - Otherwise the word is dropped and `overflow` is set.
  - A dropped word still counts toward `burst_len`.
- Pop: occurs when `out_valid`&&`out_ready`. Simultaneous push and pop leaves `level` unchanged.
- `out_valid` = (`level`!=0).
- `out_data` holds the head word and is stable while `out_valid`&&!`out_ready`. It is 0 when the FIFO is empty.
- Pointers wrap modulo DEPTH.
- Priority: `rst` > `flush` > `stop` > `start` > event/pop.
  - `flush` empties the FIFO, clears `overflow` and the accumulator, and discards a same-cycle event and pop. FSM state is unaffected.
  - `stop` concurrent with an event: the event is dropped.
- Reset values: FSM=IDLE, `level`=0, `out_valid`=0, `out_data`=0, `overflow`=0, `busy`=0, `done`=0, `code_rdy_q`=0, counters=0.

## Timing
- Event sampled at edge T: the word is in the FIFO after edge T. If the FIFO was empty, `out_valid`=1 in cycle T+1 (1-cycle latency).
- Pop at edge P: `level` decrements after P, and the next head appears in cycle P+1.
- `done` rises the cycle after the edge that writes or drops word number `burst_len`. The FSM leaves RUN on that same edge.
- Maximum sustained rate: one event per 2 cycles (the strobe must be low ≥1 cycle between events).
- `busy`, `done`, `level`, and `overflow` are all registered outputs.

## Configuration
- Macro: SAR_CAPTURE_AVG_EN.
- Defined: a 2-bit phase counter and 8-bit accumulator sum four consecutive events.
  - On the 4th event, the sum (max 252) is pushed as the word, and the phase and accumulator clear.
  - `burst_len` counts pushed words, not events.
  - The accumulator and phase clear on `start`, `stop`, `flush`, and `rst`.
- Undefined: raw words as described in Operation. No accumulator logic is present.

## Structure
- Package `sar_capture_pkg` holds:
  - CODE_W=6 and DATA_W=8
  - the FSM enum `cap_state_t` {IDLE, RUN, DONE}
- Sub-module `sar_capture_fifo` contains the synchronous FIFO storage, pointers, `level`, and push/pop logic, parameterised by DEPTH and DATA_W.
- The top level contains the FSM, edge detect, accumulator, burst counter, and overflow flag.

## Test plan
- Reset mid-run with a nonempty FIFO → all outputs return to reset values immediately; `out_valid`=0.
- `start`, `burst_len`=3, codes 0x15, 0x3F, 0x00 with `out_ready`=1 → `out_data` 0x15, 0x3F, 0x00 each one cycle after its edge; `done`=1; a fourth edge is ignored.
- `code_rdy` held high 10 cycles with code 0x2A → exactly one word 0x2A.
- `out_ready`=0, `burst_len`=0, DEPTH=8, 9 events → `level`=8, `overflow`=1, the 9th word is lost; `flush` → `level`=0, `overflow`=0.
- FIFO full with push and pop in the same cycle → `level` stays 8, no overflow, and word order is preserved.
- With SAR_CAPTURE_AVG_EN, codes 10, 20, 30, 40 → single word 100; `stop` after 2 events, then `start` and 4 codes of 1 → word 4.

Source files
------------

// File: rtl/sar_capture_pkg.sv
// Shared widths and FSM state encoding for the SAR code capture block.
package sar_capture_pkg;
    localparam int CODE_W = 6;
    localparam int DATA_W = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } cap_state_t;
endpackage

// File: rtl/sar_capture_fifo.sv
// Synchronous FIFO with registered head word, valid and occupancy; a push into a
// full FIFO is accepted only when a pop frees the slot on the same edge.
module sar_capture_fifo #(
    parameter int DEPTH  = 8,
    parameter int DATA_W = 8,
    parameter int LVL_W  = $clog2(DEPTH) + 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              push,
    input  logic [DATA_W-1:0] push_data,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              out_valid,
    output logic [LVL_W-1:0]  level,
    output logic              push_drop
);
    localparam int PTR_W = $clog2(DEPTH);

    logic [DATA_W-1:0] mem_r [DEPTH];
    logic [PTR_W-1:0]  wr_ptr_r;
    logic [PTR_W-1:0]  rd_ptr_r;
    logic [PTR_W-1:0]  rd_ptr_inc_s;
    logic [LVL_W-1:0]  level_r;
    logic [LVL_W-1:0]  level_nx_s;
    logic [DATA_W-1:0] head_r;
    logic [DATA_W-1:0] head_nx_s;
    logic              valid_r;
    logic              pop_s;
    logic              full_s;
    logic              push_ok_s;

    assign pop_s        = valid_r & out_ready & ~flush;
    assign full_s       = (level_r == LVL_W'(DEPTH));
    assign push_ok_s    = push & ~flush & (~full_s | pop_s);
    assign push_drop    = push & ~flush & ~push_ok_s;
    assign rd_ptr_inc_s = rd_ptr_r + PTR_W'(1);

    // Next occupancy and next head word after this edge's push/pop.
    always_comb begin
        level_nx_s = level_r;
        head_nx_s  = head_r;
        case ({push_ok_s, pop_s})
            2'b10:   level_nx_s = level_r + LVL_W'(1);
            2'b01:   level_nx_s = level_r - LVL_W'(1);
            default: level_nx_s = level_r;
        endcase
        if (level_nx_s == {LVL_W{1'b0}}) begin
            head_nx_s = {DATA_W{1'b0}};
        end else if (pop_s) begin
            // With one word left, the only successor is the word pushed this edge.
            head_nx_s = (level_r > LVL_W'(1)) ? mem_r[rd_ptr_inc_s] : push_data;
        end else if (level_r == {LVL_W{1'b0}}) begin
            head_nx_s = push_data;
        end else begin
            head_nx_s = head_r;
        end
    end

    // Storage, pointers and registered output view.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) mem_r[i] <= {DATA_W{1'b0}};
            wr_ptr_r <= {PTR_W{1'b0}};
            rd_ptr_r <= {PTR_W{1'b0}};
            level_r  <= {LVL_W{1'b0}};
            head_r   <= {DATA_W{1'b0}};
            valid_r  <= 1'b0;
        end else if (flush) begin
            wr_ptr_r <= {PTR_W{1'b0}};
            rd_ptr_r <= {PTR_W{1'b0}};
            level_r  <= {LVL_W{1'b0}};
            head_r   <= {DATA_W{1'b0}};
            valid_r  <= 1'b0;
        end else begin
            if (push_ok_s) begin
                mem_r[wr_ptr_r] <= push_data;
                wr_ptr_r        <= wr_ptr_r + PTR_W'(1);
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_inc_s;
            end
            level_r <= level_nx_s;
            head_r  <= head_nx_s;
            valid_r <= (level_nx_s != {LVL_W{1'b0}});
        end
    end

    assign out_data  = head_r;
    assign out_valid = valid_r;
    assign level     = level_r;
endmodule

// File: rtl/sar_code_capture.sv
// Captures SAR conversion results on the rising edge of the result strobe into a FIFO
// drained over valid/ready. Define SAR_CAPTURE_AVG_EN to push the sum of every four codes.
module sar_code_capture
    import sar_capture_pkg::*;
#(
    parameter int DEPTH = 8,
    parameter int LVL_W = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             stop,
    input  logic             flush,
    input  logic [7:0]       burst_len,
    input  logic [5:0]       code_in,
    input  logic             code_rdy,
    output logic [7:0]       out_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [LVL_W-1:0] level,
    output logic             overflow,
    output logic             busy,
    output logic             done
);
    cap_state_t        state_r;
    logic              busy_r;
    logic              done_r;
    logic              code_rdy_q_r;
    logic [7:0]        count_r;
    logic [7:0]        burst_len_r;
    logic              overflow_r;
    logic              evt_s;
    logic              word_push_s;
    logic [DATA_W-1:0] word_s;
    logic              burst_hit_s;
    logic              push_drop_s;

    // Start and stop outrank a same-cycle event, and flush discards it.
    assign evt_s = code_rdy & ~code_rdy_q_r & (state_r == RUN) & ~flush & ~stop & ~start;

`ifdef SAR_CAPTURE_AVG_EN
    logic [1:0]        phase_r;
    logic [DATA_W-1:0] acc_r;
    logic [DATA_W-1:0] sum_s;

    assign sum_s       = acc_r + {{(DATA_W-CODE_W){1'b0}}, code_in};
    assign word_push_s = evt_s & (phase_r == 2'd3);
    assign word_s      = sum_s;

    // Four-event accumulator; cleared by any run control or flush.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            phase_r <= 2'd0;
            acc_r   <= {DATA_W{1'b0}};
        end else if (flush || stop || start) begin
            phase_r <= 2'd0;
            acc_r   <= {DATA_W{1'b0}};
        end else if (evt_s) begin
            phase_r <= phase_r + 2'd1;
            acc_r   <= (phase_r == 2'd3) ? {DATA_W{1'b0}} : sum_s;
        end
    end
`else
    assign word_push_s = evt_s;
    assign word_s      = {{(DATA_W-CODE_W){1'b0}}, code_in};
`endif

    assign burst_hit_s = (burst_len_r != 8'd0) && ((count_r + 8'd1) == burst_len_r);

    // Strobe history for edge detection; tracks in every state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            code_rdy_q_r <= 1'b0;
        end else begin
            code_rdy_q_r <= code_rdy;
        end
    end

    // Run-control FSM with burst counter and registered busy/done.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r     <= IDLE;
            busy_r      <= 1'b0;
            done_r      <= 1'b0;
            count_r     <= 8'd0;
            burst_len_r <= 8'd0;
        end else if (stop) begin
            state_r <= IDLE;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
        end else if (start) begin
            state_r     <= RUN;
            busy_r      <= 1'b1;
            done_r      <= 1'b0;
            count_r     <= 8'd0;
            burst_len_r <= burst_len;
        end else begin
            case (state_r)
                RUN: begin
                    if (word_push_s) begin
                        count_r <= count_r + 8'd1;
                        if (burst_hit_s) begin
                            state_r <= DONE;
                            busy_r  <= 1'b0;
                            done_r  <= 1'b1;
                        end
                    end
                end
                IDLE, DONE: begin
                    state_r <= state_r;
                end
                default: begin
                    state_r <= IDLE;
                    busy_r  <= 1'b0;
                    done_r  <= 1'b0;
                end
            endcase
        end
    end

    // Sticky drop indicator; only flush or reset clears it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            overflow_r <= 1'b0;
        end else if (flush) begin
            overflow_r <= 1'b0;
        end else if (push_drop_s) begin
            overflow_r <= 1'b1;
        end
    end

    sar_capture_fifo #(
        .DEPTH  (DEPTH),
        .DATA_W (DATA_W),
        .LVL_W  (LVL_W)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .push      (word_push_s),
        .push_data (word_s),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_valid (out_valid),
        .level     (level),
        .push_drop (push_drop_s)
    );

    assign busy     = busy_r;
    assign done     = done_r;
    assign overflow = overflow_r;
endmodule

// File: tb/tb_sar_code_capture.sv
// Directed bench for sar_code_capture with a scoreboard of expected FIFO output words.
module tb_sar_code_capture;
    logic       clk = 1'b0;
    logic       rst;
    logic       start, stop, flush;
    logic [7:0] burst_len;
    logic [5:0] code_in;
    logic       code_rdy;
    logic [7:0] out_data;
    logic       out_valid;
    logic       out_ready;
    logic [3:0] level;
    logic       overflow, busy, done;

    int         pass_cnt = 0;
    int         total_cnt = 0;
    int         fail_cnt = 0;
    logic [7:0] sb [$];

    always #5 clk = ~clk;

    sar_code_capture #(.DEPTH(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .stop      (stop),
        .flush     (flush),
        .burst_len (burst_len),
        .code_in   (code_in),
        .code_rdy  (code_rdy),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .level     (level),
        .overflow  (overflow),
        .busy      (busy),
        .done      (done)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total_cnt++;
        assert (obs === exp) pass_cnt++;
        else begin
            fail_cnt++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Every accepted word must match the oldest expected word.
    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            if (sb.size() == 0) begin
                check("unexpected_pop", 32'(sb.size()), 32'd1);
            end else begin
                check("pop_data", 32'(out_data), 32'(sb.pop_front()));
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start(input logic [7:0] len);
        burst_len = len;
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    task automatic pulse_stop();
        stop = 1'b1;
        step();
        stop = 1'b0;
    endtask

    task automatic send_code(input logic [5:0] c, input bit chk);
        code_in  = c;
        code_rdy = 1'b1;
        step();
        if (chk) begin
            check("evt_valid", 32'(out_valid), 32'd1);
            check("evt_data", 32'(out_data), 32'(c));
        end
        code_rdy = 1'b0;
        step();
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; stop = 1'b0; flush = 1'b0;
        burst_len = 8'd0; code_in = 6'd0; code_rdy = 1'b0; out_ready = 1'b0;
        repeat (3) step();
        check("rst_level", 32'(level), 32'd0);
        check("rst_valid", 32'(out_valid), 32'd0);
        check("rst_data", 32'(out_data), 32'd0);
        check("rst_overflow", 32'(overflow), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        rst = 1'b0;
        step();

`ifdef SAR_CAPTURE_AVG_EN
        pulse_start(8'd0);
        sb.push_back(8'd100);
        send_code(6'd10, 1'b0);
        send_code(6'd20, 1'b0);
        send_code(6'd30, 1'b0);
        send_code(6'd40, 1'b0);
        check("avg_level", 32'(level), 32'd1);
        check("avg_data", 32'(out_data), 32'd100);
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        send_code(6'd1, 1'b0);
        send_code(6'd1, 1'b0);
        pulse_stop();
        pulse_start(8'd0);
        sb.push_back(8'd4);
        for (int i = 0; i < 4; i++) send_code(6'd1, 1'b0);
        check("avg_restart_level", 32'(level), 32'd1);
        check("avg_restart_data", 32'(out_data), 32'd4);
        out_ready = 1'b1;
        step();
        step();
        check("avg_drained", 32'(level), 32'd0);
        out_ready = 1'b0;
`else
        // Burst of three with an always-ready consumer.
        out_ready = 1'b1;
        pulse_start(8'd3);
        check("burst_busy", 32'(busy), 32'd1);
        sb.push_back(8'h15);
        send_code(6'h15, 1'b1);
        sb.push_back(8'h3F);
        send_code(6'h3F, 1'b1);
        sb.push_back(8'h00);
        code_in = 6'h00;
        code_rdy = 1'b1;
        step();
        check("last_valid", 32'(out_valid), 32'd1);
        check("last_data", 32'(out_data), 32'd0);
        check("burst_done", 32'(done), 32'd1);
        check("burst_not_busy", 32'(busy), 32'd0);
        code_rdy = 1'b0;
        step();
        send_code(6'h11, 1'b0);
        check("fourth_ignored", 32'(level), 32'd0);
        check("fourth_no_valid", 32'(out_valid), 32'd0);

        // Held-high strobe yields one word.
        pulse_stop();
        out_ready = 1'b0;
        pulse_start(8'd0);
        code_in = 6'h2A;
        code_rdy = 1'b1;
        repeat (10) step();
        code_rdy = 1'b0;
        step();
        check("held_level", 32'(level), 32'd1);
        check("held_data", 32'(out_data), 32'h2A);
        sb.push_back(8'h2A);
        out_ready = 1'b1;
        step();
        step();
        check("held_drained", 32'(level), 32'd0);

        // Overflow: nine events into eight slots, then flush.
        out_ready = 1'b0;
        for (int i = 1; i <= 9; i++) send_code(6'(i), 1'b0);
        check("ovf_level", 32'(level), 32'd8);
        check("ovf_flag", 32'(overflow), 32'd1);
        check("ovf_head", 32'(out_data), 32'd1);
        flush = 1'b1;
        step();
        flush = 1'b0;
        check("flush_level", 32'(level), 32'd0);
        check("flush_ovf", 32'(overflow), 32'd0);
        check("flush_valid", 32'(out_valid), 32'd0);

        // Full FIFO with simultaneous push and pop.
        for (int i = 0; i < 8; i++) begin
            sb.push_back(8'(8'h10 + i));
            send_code(6'(6'h10 + i), 1'b0);
        end
        check("full_level", 32'(level), 32'd8);
        sb.push_back(8'h20);
        code_in = 6'h20;
        code_rdy = 1'b1;
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        code_rdy = 1'b0;
        check("pushpop_level", 32'(level), 32'd8);
        check("pushpop_ovf", 32'(overflow), 32'd0);
        check("pushpop_head", 32'(out_data), 32'h11);
        step();
        out_ready = 1'b1;
        for (int i = 0; i < 20 && level != 4'd0; i++) step();
        check("drain_level", 32'(level), 32'd0);
        check("drain_sb_empty", 32'(sb.size()), 32'd0);

        // Stop concurrent with an event drops the event.
        out_ready = 1'b0;
        code_in = 6'h05;
        code_rdy = 1'b1;
        stop = 1'b1;
        step();
        stop = 1'b0;
        code_rdy = 1'b0;
        step();
        check("stop_evt_level", 32'(level), 32'd0);
        check("stop_busy", 32'(busy), 32'd0);
`endif

        // Asynchronous reset mid-run with a nonempty FIFO.
        out_ready = 1'b0;
        pulse_start(8'd0);
        for (int i = 0; i < 8; i++) send_code(6'h33, 1'b0);
        check("pre_rst_level", 32'(level), 32'(`ifdef SAR_CAPTURE_AVG_EN 2 `else 8 `endif));
        #3;
        rst = 1'b1;
        #1;
        check("arst_level", 32'(level), 32'd0);
        check("arst_valid", 32'(out_valid), 32'd0);
        check("arst_data", 32'(out_data), 32'd0);
        check("arst_busy", 32'(busy), 32'd0);
        sb.delete();
        step();
        rst = 1'b0;
        step();

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule
